seven_segment_scanner: RTL and testbench

- Multi-digit hex display driver that converts values into seven-segment patterns.
- Accepts a packed hex value over a load/ready handshake and time-multiplexes it onto a shared 7-bit segment bus with one-hot digit enables.
- Uses the team's standard abcdefg segment encoding, so its output decodes back to the same nibbles on the display-reading side.
- Sits between the datapath and the physical display pins.

---
 rtl/seven_segment_scanner.sv | 154 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed hex display driver: accepts a packed hex value and scans it onto a
// shared abcdefg segment bus with one-hot digit enables and frame-aligned updates.
module seven_segment_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int unsigned VAL_W    = 4 * DIGITS;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [VAL_W-1:0]   shown, shown_n, pend, pend_n;
  logic               shown_blz, shown_blz_n, pend_blz, pend_blz_n;
  logic               pending, pending_n;
  logic               ready_n, frame_done_n;
  logic [6:0]         segments_n;
  logic [DIGITS-1:0]  digit_en_n;
  logic               accept_c, frame_end_c, upper_zero_c;
  logic [3:0]         nib_c;

  function automatic logic [6:0] encode(input logic [3:0] n);
    case (n)
      4'h0: encode = 7'b1111110;
      4'h1: encode = 7'b0110000;
      4'h2: encode = 7'b1101101;
      4'h3: encode = 7'b1111001;
      4'h4: encode = 7'b0110011;
      4'h5: encode = 7'b1011011;
      4'h6: encode = 7'b1011111;
      4'h7: encode = 7'b1110000;
      4'h8: encode = 7'b1111111;
      4'h9: encode = 7'b1110011;
      4'hA: encode = 7'b1110111;
      4'hB: encode = 7'b0011111;
      4'hC: encode = 7'b1001110;
      4'hD: encode = 7'b0111101;
      4'hE: encode = 7'b1001111;
      default: encode = 7'b1000111;
    endcase
  endfunction

  // State register; outputs are registered copies of the decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      div        <= '0;
      shown      <= '0;
      shown_blz  <= 1'b0;
      pend       <= '0;
      pend_blz   <= 1'b0;
      pending    <= 1'b0;
      ready      <= 1'b1;
      segments   <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      div        <= div_n;
      shown      <= shown_n;
      shown_blz  <= shown_blz_n;
      pend       <= pend_n;
      pend_blz   <= pend_blz_n;
      pending    <= pending_n;
      ready      <= ready_n;
      segments   <= segments_n;
      digit_en   <= digit_en_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    div_n        = div;
    shown_n      = shown;
    shown_blz_n  = shown_blz;
    pend_n       = pend;
    pend_blz_n   = pend_blz;
    pending_n    = pending;
    segments_n   = '0;
    digit_en_n   = '0;
    frame_done_n = 1'b0;
    nib_c        = 4'h0;
    upper_zero_c = 1'b1;
    accept_c     = load && ready;
    frame_end_c  = (state == SCAN) && (idx == IDX_LAST) && (div == DIV_LAST);

    case (state)
      IDLE: begin
        if (accept_c) begin
          state_n     = SCAN;
          shown_n     = value;
          shown_blz_n = blank_lz;
          idx_n       = '0;
          div_n       = '0;
        end
      end
      SCAN: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          div_n = div + DIV_W'(1);
        end
        // Updates land only on frame boundaries; a load coinciding with one bypasses the pending slot.
        if (frame_end_c && pending) begin
          shown_n     = pend;
          shown_blz_n = pend_blz;
          pending_n   = 1'b0;
        end else if (frame_end_c && accept_c) begin
          shown_n     = value;
          shown_blz_n = blank_lz;
        end else if (accept_c) begin
          pend_n     = value;
          pend_blz_n = blank_lz;
          pending_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = !pending_n;

    if (state_n == SCAN) begin
      for (int j = 0; j < int'(DIGITS); j++) begin
        if (j == int'(idx_n)) nib_c = shown_n[j*4 +: 4];
        if (j >= int'(idx_n) && shown_n[j*4 +: 4] != 4'h0) upper_zero_c = 1'b0;
      end
      digit_en_n   = DIGITS'(1) << idx_n;
      segments_n   = (shown_blz_n && idx_n != '0 && upper_zero_c) ? 7'b0000000 : encode(nib_c);
      frame_done_n = (idx_n == IDX_LAST) && (div_n == DIV_LAST);
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (DIGITS=4, REFRESH_DIV=4) with
// hand-computed segment patterns and immediate-assertion checks.
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        ready;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int vectors;
  int miscompares;
  logic [6:0] exp_seg [4];

  seven_segment_scanner #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .ready      (ready),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] en, input logic [6:0] seg,
                         input logic rdy, input logic fd);
    chk({tag, ".digit_en"},   32'(digit_en),   32'(en));
    chk({tag, ".segments"},   32'(segments),   32'(seg));
    chk({tag, ".ready"},      32'(ready),      32'(rdy));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    load        = 1'b0;
    value       = 16'h0000;
    blank_lz    = 1'b0;

    @(negedge clk);
    step(); step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("idle%0d", i), 4'b0000, 7'b0000000, 1'b1, 1'b0);
      step();
    end

    // Frame 1: 12AF, load 0000 during digit 1, a second load while busy is dropped.
    load = 1'b1; value = 16'h12AF; blank_lz = 1'b0;
    step();
    load = 1'b0;
    exp_seg = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};
    for (int c = 1; c <= 16; c++) begin
      int d;
      d = (c - 1) / 4;
      chk_all($sformatf("f1c%0d", c), 4'(1 << d), exp_seg[d], (c <= 6), (c == 16));
      load  = (c == 6) || (c == 10);
      value = (c == 6) ? 16'h0000 : 16'h5555;
      step();
    end
    load = 1'b0;

    // Frame 2: pending 0000 is shown; load in the frame_done cycle bypasses to shown.
    for (int c = 17; c <= 32; c++) begin
      int d;
      d = (c - 17) / 4;
      chk_all($sformatf("f2c%0d", c), 4'(1 << d), 7'b1111110, 1'b1, (c == 32));
      if (c == 32) begin
        load = 1'b1; value = 16'h0030; blank_lz = 1'b1;
      end
      step();
      load = 1'b0;
    end

    // Frame 3: 0030 with leading-zero blanking.
    exp_seg = '{7'b1111110, 7'b1111001, 7'b0000000, 7'b0000000};
    for (int c = 33; c <= 48; c++) begin
      int d;
      d = (c - 33) / 4;
      chk_all($sformatf("f3c%0d", c), 4'(1 << d), exp_seg[d], 1'b1, (c == 48));
      step();
    end

    // Frame 4: queue 8888, then reset while digit 2 is enabled.
    for (int c = 49; c <= 57; c++) begin
      int d;
      d = (c - 49) / 4;
      chk_all($sformatf("f4c%0d", c), 4'(1 << d), exp_seg[d], (c == 49), 1'b0);
      load = (c == 49); value = 16'h8888; blank_lz = 1'b0;
      rst  = (c == 57);
      step();
    end
    load = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_all($sformatf("post_rst%0d", i), 4'b0000, 7'b0000000, 1'b1, 1'b0);
      step();
    end

    // Fresh load after reset: 00F0 with blanking.
    load = 1'b1; value = 16'h00F0; blank_lz = 1'b1;
    step();
    load = 1'b0;
    exp_seg = '{7'b1111110, 7'b1000111, 7'b0000000, 7'b0000000};
    for (int c = 1; c <= 16; c++) begin
      int d;
      d = (c - 1) / 4;
      chk_all($sformatf("f5c%0d", c), 4'(1 << d), exp_seg[d], 1'b1, (c == 16));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
